// File: rtl/adc_sequencer.sv
// Round-robin Avalon-ST initiator for the modular ADC core: one command in flight,
// box-car averaging of 2**AVG_LOG2 samples per slot, registered 12-bit results.
module adc_sequencer #(
    parameter int NUM_CH   = 2,
    parameter int CH_BASE  = 1,
    parameter int AVG_LOG2 = 3,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 enable,
    output logic                 adc_command_valid,
    output logic [4:0]           adc_command_channel,
    output logic                 adc_command_startofpacket,
    output logic                 adc_command_endofpacket,
    input  logic                 adc_command_ready,
    input  logic                 adc_response_valid,
    input  logic [4:0]           adc_response_channel,
    input  logic [11:0]          adc_response_data,
    input  logic                 adc_response_startofpacket,
    input  logic                 adc_response_endofpacket,
    output logic [NUM_CH*12-1:0] ch_value,
    output logic [NUM_CH-1:0]    ch_update,
    output logic                 frame_done,
    output logic [7:0]           error_count
);

    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'((1 << AVG_LOG2) - 1);
    // The timeout fires on the edge where the timer would reach TIMEOUT.
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT_RSP} state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ACC_W-1:0]    acc_q [NUM_CH];
    logic [ACC_W-1:0]    acc_d [NUM_CH];
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [11:0]         value_q [NUM_CH];
    logic [11:0]         value_d [NUM_CH];
    logic [NUM_CH-1:0]   update_q, update_d;
    logic                frame_q, frame_d;
    logic [7:0]          err_q, err_d;

    logic [4:0]          slot_ch;
    logic                rsp_match;
    logic [ACC_W-1:0]    sum;
    logic                err_event;
    logic                unused_rsp_framing;

    assign unused_rsp_framing = adc_response_startofpacket ^ adc_response_endofpacket;
    assign slot_ch   = 5'(CH_BASE) + 5'(slot_q);
    assign rsp_match = adc_response_valid && (adc_response_channel == slot_ch);
    assign sum       = acc_q[slot_q] + ACC_W'(adc_response_data);

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d   = state_q;
        slot_d    = slot_q;
        timer_d   = timer_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        update_d  = '0;
        frame_d   = 1'b0;
        err_event = 1'b0;

        case (state_q)
            IDLE: begin
                err_event = adc_response_valid;
                if (enable) state_d = CMD;
            end
            CMD: begin
                err_event = adc_response_valid;
                if (adc_command_ready) begin
                    state_d = WAIT_RSP;
                    timer_d = '0;
                end
            end
            WAIT_RSP: begin
                timer_d = timer_q + TMR_W'(1);
                if (rsp_match) begin
                    if (cnt_q[slot_q] == CNT_MAX) begin
                        value_d[slot_q]  = 12'(sum >> AVG_LOG2);
                        acc_d[slot_q]    = '0;
                        cnt_d[slot_q]    = '0;
                        update_d[slot_q] = 1'b1;
                    end else begin
                        acc_d[slot_q] = sum;
                        cnt_d[slot_q] = cnt_q[slot_q] + CNT_W'(1);
                    end
                    frame_d = (slot_q == LAST_SLOT);
                    slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
                    state_d = enable ? CMD : IDLE;
                end else begin
                    err_event = adc_response_valid;
                    if (timer_q == TMR_LAST) begin
                        err_event = 1'b1;
                        state_d   = CMD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = (err_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            timer_q  <= '0;
            update_q <= '0;
            frame_q  <= 1'b0;
            err_q    <= '0;
            // NOTE: the per-slot arrays are small register files that must start from zero,
            // so they are reset explicitly rather than left to power-up contents.
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]   <= '0;
                cnt_q[i]   <= '0;
                value_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            slot_q   <= slot_d;
            timer_q  <= timer_d;
            update_q <= update_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
        end
    end

    assign adc_command_valid         = (state_q == CMD);
    assign adc_command_startofpacket = adc_command_valid;
    assign adc_command_endofpacket   = adc_command_valid;
    assign adc_command_channel       = adc_command_valid ? slot_ch : 5'd0;
    assign ch_update                 = update_q;
    assign frame_done                = frame_q;
    assign error_count               = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_value
        assign ch_value[12*g +: 12] = value_q[g];
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: two instances share stimulus, one averaging
// four samples and one publishing every sample, both with a 15-cycle timeout.
module tb_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ready;
    logic        rsp_valid;
    logic [4:0]  rsp_ch;
    logic [11:0] rsp_data;

    logic        a_valid, a_sop, a_eop, a_frame;
    logic [4:0]  a_ch;
    logic [23:0] a_value;
    logic [1:0]  a_upd;
    logic [7:0]  a_err;

    logic        b_valid, b_sop, b_eop, b_frame;
    logic [4:0]  b_ch;
    logic [23:0] b_value;
    logic [1:0]  b_upd;
    logic [7:0]  b_err;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;
    int frame_cnt = 0;
    int upd0_cnt = 0;

    always #5 clk = ~clk;

    adc_sequencer #(.NUM_CH(2), .CH_BASE(1), .AVG_LOG2(2), .TIMEOUT(15)) dut_a (
        .clk_clk(clk), .reset_reset(rst), .enable(enable),
        .adc_command_valid(a_valid), .adc_command_channel(a_ch),
        .adc_command_startofpacket(a_sop), .adc_command_endofpacket(a_eop),
        .adc_command_ready(ready),
        .adc_response_valid(rsp_valid), .adc_response_channel(rsp_ch),
        .adc_response_data(rsp_data),
        .adc_response_startofpacket(rsp_valid), .adc_response_endofpacket(rsp_valid),
        .ch_value(a_value), .ch_update(a_upd), .frame_done(a_frame), .error_count(a_err)
    );

    adc_sequencer #(.NUM_CH(2), .CH_BASE(1), .AVG_LOG2(0), .TIMEOUT(15)) dut_b (
        .clk_clk(clk), .reset_reset(rst), .enable(enable),
        .adc_command_valid(b_valid), .adc_command_channel(b_ch),
        .adc_command_startofpacket(b_sop), .adc_command_endofpacket(b_eop),
        .adc_command_ready(ready),
        .adc_response_valid(rsp_valid), .adc_response_channel(rsp_ch),
        .adc_response_data(rsp_data),
        .adc_response_startofpacket(rsp_valid), .adc_response_endofpacket(rsp_valid),
        .ch_value(b_value), .ch_update(b_upd), .frame_done(b_frame), .error_count(b_err)
    );

    always @(negedge clk) begin
        if (a_valid && ready) xfer_cnt++;
        if (a_frame) frame_cnt++;
        if (a_upd[0]) upd0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Ends at a negedge with the command valid (or the wait budget spent).
    task automatic wait_cmd(input string tag, input logic [4:0] exp_ch);
        int n = 0;
        @(negedge clk);
        while (!a_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(a_valid), 32'd1);
        check({tag, "_ch"}, 32'(a_ch), 32'(exp_ch));
    endtask

    // From a negedge with valid high: raise ready for exactly one transfer edge.
    task automatic accept();
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
    endtask

    task automatic respond(input logic [4:0] ch, input logic [11:0] data);
        rsp_valid = 1'b1;
        rsp_ch    = ch;
        rsp_data  = data;
        @(posedge clk); #1 rsp_valid = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic [4:0] ch, input logic [11:0] data);
        wait_cmd(tag, ch);
        accept();
        respond(ch, data);
        @(negedge clk);
        check({tag, "_b2b"}, 32'(a_valid), 32'd1);
    endtask

    initial begin
        int f0, u0, t0, e0;
        rst = 1'b1; enable = 1'b0; ready = 1'b0;
        rsp_valid = 1'b0; rsp_ch = '0; rsp_data = '0;
        #1;
        check("reset_cmd", {a_valid, a_sop, a_eop, a_ch}, 32'd0);
        check("reset_value", 32'(a_value), 32'd0);
        check("reset_misc", {a_upd, a_frame, a_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Enable latency: valid appears the cycle after the enabling edge.
        @(posedge clk); #1 enable = 1'b1;
        @(negedge clk);
        check("en_lat_before", 32'(a_valid), 32'd0);
        @(negedge clk);
        check("en_lat_after", 32'(a_valid), 32'd1);

        // Averaging across two slots, commands alternating 1,2.
        f0 = frame_cnt; u0 = upd0_cnt; t0 = xfer_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) do_txn("avg", 5'd2, 12'd40);
            else            do_txn("avg", 5'd1, 12'(100 * (i / 2 + 1)));
        end
        #1;
        check("avg_slot0", 32'(a_value[11:0]), 32'd250);
        check("avg_slot1", 32'(a_value[23:12]), 32'd40);
        check("raw_slot0", 32'(b_value[11:0]), 32'd400);
        check("raw_slot1", 32'(b_value[23:12]), 32'd40);
        check("avg_frames", 32'(frame_cnt - f0), 32'd4);
        check("avg_upd0", 32'(upd0_cnt - u0), 32'd1);
        check("avg_xfers", 32'(xfer_cnt - t0), 32'd8);
        check("avg_err", 32'(a_err), 32'd0);

        // Ready held low for five cycles: command stays stable, one transfer.
        wait_cmd("stall", 5'd1);
        t0 = xfer_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_stable", {a_valid, a_sop, a_eop, a_ch}, {24'd0, 3'b111, 5'd1});
        end
        accept();
        respond(5'd1, 12'd8);
        @(negedge clk); #1;
        check("stall_xfers", 32'(xfer_cnt - t0), 32'd1);
        check("stall_err", 32'(a_err), 32'd0);

        // Timeout: reissue exactly TIMEOUT+1 cycles after acceptance.
        wait_cmd("to", 5'd2);
        e0 = int'(a_err);
        accept();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 15) check("to_quiet", 32'(a_valid), 32'd0);
            if (i == 16) begin
                check("to_reissue", 32'(a_valid), 32'd1);
                check("to_reissue_ch", 32'(a_ch), 32'd2);
            end
        end
        check("to_err", 32'(a_err), 32'(e0 + 1));

        // A matching response on the timeout edge wins.
        accept();
        repeat (14) @(posedge clk);
        #1 respond(5'd2, 12'd40);
        @(negedge clk);
        check("to_edge_err", 32'(a_err), 32'(e0 + 1));
        check("to_edge_next_ch", 32'(a_ch), 32'd1);

        // Wrong channel beat is counted and discarded.
        accept();
        respond(5'd7, 12'd1000);
        respond(5'd1, 12'd4095);
        @(negedge clk);
        check("wrong_err", 32'(a_err), 32'(e0 + 2));
        check("wrong_raw_slot0", 32'(b_value[11:0]), 32'd4095);

        // Enable dropped mid-wait: response accepted, then park in IDLE.
        wait_cmd("en", 5'd2);
        accept();
        enable = 1'b0;
        respond(5'd2, 12'd60);
        @(negedge clk);
        check("en_frame", 32'(a_frame), 32'd1);
        check("en_park", 32'(a_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("en_park_hold", 32'(a_valid), 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        wait_cmd("resume", 5'd1);

        // Reset in the middle of a wait on slot 1 with its accumulator nonzero.
        accept();
        respond(5'd1, 12'd8);
        wait_cmd("pre_rst", 5'd2);
        accept();
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("rst_cmd", {a_valid, a_sop, a_eop, a_ch}, 32'd0);
        check("rst_value", 32'(a_value), 32'd0);
        check("rst_raw_value", 32'(b_value), 32'd0);
        check("rst_misc", {a_upd, a_frame, a_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_cmd("post_rst", 5'd1);

        // Unmatched responses saturate the error counter.
        @(posedge clk); #1;
        rsp_valid = 1'b1; rsp_ch = 5'd5; rsp_data = 12'd1;
        repeat (300) @(posedge clk);
        #1 rsp_valid = 1'b0;
        @(negedge clk);
        check("err_saturate", 32'(a_err), 32'd255);
        check("err_saturate_b", 32'(b_err), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
